// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc. Operation request (in_*, a, b, aluc) plus registered result (out_*, s, busy).
// The optional zero flag z exists only when ALU_MC_ZFLAG_EN is defined.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             busy;
`ifdef ALU_MC_ZFLAG_EN
  logic             z;

  modport master (
    output in_valid, a, b, aluc, out_ready,
    input  in_ready, out_valid, s, busy, z
  );
  modport slave (
    input  in_valid, a, b, aluc, out_ready,
    output in_ready, out_valid, s, busy, z
  );
`else
  modport master (
    output in_valid, a, b, aluc, out_ready,
    input  in_ready, out_valid, s, busy
  );
  modport slave (
    input  in_valid, a, b, aluc, out_ready,
    output in_ready, out_valid, s, busy
  );
`endif
endinterface

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes; latency 1 for most ops, WIDTH/HAM_STEP+1 for Hamming distance.
// Accepts only when idle and the output slot is free or draining. ALU_MC_ZFLAG_EN adds a registered zero flag z.
module alu_mc #(
  parameter int WIDTH    = 32,
  parameter int HAM_STEP = 4
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int N   = WIDTH / HAM_STEP;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] res;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    chunk_pc;
  logic [AW-1:0]    acc_nxt;
  logic [CW-1:0]    cnt;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_c;
  logic             accept;
  logic             is_ham;
  logic [SHW-1:0]   sh;

  assign in_ready_c    = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.busy      = busy_q;
  assign sh            = bus.a[SHW-1:0];
  assign is_ham        = (bus.aluc == 4'b1110);

  // 1110 must win over the x110 LUI pattern, so it is listed first
  always_comb begin
    res = '0;
    casez (bus.aluc)
      4'b1110: res = '0;
      4'b?000: res = bus.a + bus.b;
      4'b?100: res = bus.a - bus.b;
      4'b?001: res = bus.a & bus.b;
      4'b?101: res = bus.a | bus.b;
      4'b?010: res = bus.a ^ bus.b;
      4'b0110: res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0011: res = bus.b << sh;
      4'b0111: res = bus.b >> sh;
      4'b1111: res = $signed(bus.b) >>> sh;
      default: res = '0;
    endcase
  end

  always_comb begin
    chunk_pc = '0;
    for (int i = 0; i < HAM_STEP; i++) begin
      chunk_pc = chunk_pc + AW'(x_q[i]);
    end
  end

  assign acc_nxt = acc + chunk_pc;

`ifdef ALU_MC_ZFLAG_EN
  logic z_q;
  assign bus.z = z_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_q         <= '0;
      s_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_MC_ZFLAG_EN
      z_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_ham) begin
              // Previous result is either absent or draining this edge
              x_q         <= bus.a ^ bus.b;
              acc         <= '0;
              cnt         <= '0;
              state       <= BUSY;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              s_q         <= res;
              out_valid_q <= 1'b1;
`ifdef ALU_MC_ZFLAG_EN
              z_q         <= (res == '0);
`endif
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          x_q <= x_q >> HAM_STEP;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            s_q         <= {{(WIDTH-AW){1'b0}}, acc_nxt};
            out_valid_q <= 1'b1;
            state       <= IDLE;
            busy_q      <= 1'b0;
`ifdef ALU_MC_ZFLAG_EN
            z_q         <= (acc_nxt == '0);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
